// File: rtl/tpg_regs_pkg.sv
// Shared definitions for the test pattern generator AXI4-Lite register block:
// register offsets, CTRL bit positions, response codes and the frame config payload.
package tpg_regs_pkg;

    localparam int unsigned AXI_ADDR_W = 12;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned CFG_DIM_W  = 16;

    localparam logic [AXI_ADDR_W-1:0] OFF_CTRL         = 12'h000;
    localparam logic [AXI_ADDR_W-1:0] OFF_ACTIVE_H     = 12'h010;
    localparam logic [AXI_ADDR_W-1:0] OFF_ACTIVE_W     = 12'h018;
    localparam logic [AXI_ADDR_W-1:0] OFF_BG_PATTERN   = 12'h020;
    localparam logic [AXI_ADDR_W-1:0] OFF_COLOR_FORMAT = 12'h040;

    localparam int unsigned CTRL_AP_START     = 0;
    localparam int unsigned CTRL_AP_DONE      = 1;
    localparam int unsigned CTRL_AP_IDLE      = 2;
    localparam int unsigned CTRL_AP_READY     = 3;
    localparam int unsigned CTRL_AUTO_RESTART = 7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [CFG_DIM_W-1:0] height;
        logic [CFG_DIM_W-1:0] width;
        logic [7:0]           bg_id;
        logic [7:0]           color_fmt;
    } tpg_cfg_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    // Byte lanes [1:0] of the address carry no meaning for 32-bit registers.
    function automatic logic [AXI_ADDR_W-1:0] word_addr(input logic [AXI_ADDR_W-1:0] addr);
        return addr & ~AXI_ADDR_W'(3);
    endfunction

    function automatic logic reg_mapped(input logic [AXI_ADDR_W-1:0] addr);
        logic [AXI_ADDR_W-1:0] w;
        w = word_addr(addr);
        return (w == OFF_CTRL) || (w == OFF_ACTIVE_H) || (w == OFF_ACTIVE_W) ||
               (w == OFF_BG_PATTERN) || (w == OFF_COLOR_FORMAT);
    endfunction

    function automatic logic [AXI_DATA_W-1:0] apply_strb(
        input logic [AXI_DATA_W-1:0] old_val,
        input logic [AXI_DATA_W-1:0] new_val,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(AXI_STRB_W); i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite slave channel handling: AW/W/B and AR/R state machines presenting a
// simple single-cycle register write/read strobe interface to the register file.
module axil_slave_if
    import tpg_regs_pkg::*;
(
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [AXI_DATA_W-1:0] s_axi_wdata,
    input  logic [AXI_STRB_W-1:0] s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [AXI_DATA_W-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  wr_en,
    output logic [AXI_ADDR_W-1:0] wr_addr,
    output logic [AXI_DATA_W-1:0] wr_data,
    output logic [AXI_STRB_W-1:0] wr_strb,
    output logic                  rd_en,
    output logic [AXI_ADDR_W-1:0] rd_addr,
    input  logic [AXI_DATA_W-1:0] rd_data,
    input  logic                  rd_err
);

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic [AXI_ADDR_W-1:0] awaddr_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [AXI_STRB_W-1:0] wstrb_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // Commit strobe: fires in the cycle the second of address/data is taken.
    always_comb begin
        wr_en = 1'b0;
        case (wr_state)
            WR_IDLE:    wr_en = aw_hs && w_hs;
            WR_HAVE_AW: wr_en = w_hs;
            WR_HAVE_W:  wr_en = aw_hs;
            default:    wr_en = 1'b0;
        endcase
    end

    assign wr_addr = (wr_state == WR_HAVE_AW) ? awaddr_q : s_axi_awaddr;
    assign wr_data = (wr_state == WR_HAVE_W)  ? wdata_q  : s_axi_wdata;
    assign wr_strb = (wr_state == WR_HAVE_W)  ? wstrb_q  : s_axi_wstrb;

    assign rd_en   = ar_hs;
    assign rd_addr = s_axi_araddr;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state      <= WR_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else if (wr_en) begin
            wr_state      <= WR_RESP;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= reg_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        wr_state      <= WR_HAVE_AW;
                        awaddr_q      <= s_axi_awaddr;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                    end else if (w_hs) begin
                        wr_state      <= WR_HAVE_W;
                        wdata_q       <= s_axi_wdata;
                        wstrb_q       <= s_axi_wstrb;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b0;
                    end else begin
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                WR_HAVE_AW: begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b1;
                end
                WR_HAVE_W: begin
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b0;
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        wr_state      <= WR_IDLE;
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read data is captured on the AR handshake so a same-cycle write is not visible.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state      <= RD_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state      <= RD_RESP;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= rd_data;
                        s_axi_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        rd_state      <= RD_IDLE;
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tpg_axil_regs.sv
// Register file and ap_start/ap_ready/ap_done control for the test pattern generator,
// with frame parameters shadowed so they only change when the core takes a start.
module tpg_axil_regs
    import tpg_regs_pkg::*;
#(
    parameter int unsigned ADDR_W = AXI_ADDR_W,
    parameter int unsigned DATA_W = AXI_DATA_W,
    parameter int unsigned DIM_W  = CFG_DIM_W
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic [DIM_W-1:0]  frame_height,
    output logic [DIM_W-1:0]  frame_width,
    output logic [7:0]        frame_bg_id,
    output logic [7:0]        frame_color_fmt
);

    logic                  wr_en;
    logic [AXI_ADDR_W-1:0] wr_addr;
    logic [AXI_DATA_W-1:0] wr_data;
    logic [AXI_STRB_W-1:0] wr_strb;
    logic                  rd_en;
    logic [AXI_ADDR_W-1:0] rd_addr;
    logic [AXI_DATA_W-1:0] rd_data;
    logic                  rd_err;

    logic [AXI_ADDR_W-1:0] wr_word;
    logic [AXI_ADDR_W-1:0] rd_word;
    logic                  wr_ctrl;
    logic                  rd_ctrl;

    tpg_cfg_t cfg_q;
    tpg_cfg_t shadow_q;
    logic     auto_restart_q;
    logic     done_q;
    logic     ready_q;

    axil_slave_if u_axil_slave_if (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_err        (rd_err)
    );

    assign wr_word = word_addr(wr_addr);
    assign rd_word = word_addr(rd_addr);
    assign wr_ctrl = wr_en && (wr_word == OFF_CTRL);
    assign rd_ctrl = rd_en && (rd_word == OFF_CTRL);

    assign frame_height    = shadow_q.height;
    assign frame_width     = shadow_q.width;
    assign frame_bg_id     = shadow_q.bg_id;
    assign frame_color_fmt = shadow_q.color_fmt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            cfg_q          <= '0;
            shadow_q       <= '0;
            ap_start       <= 1'b0;
            auto_restart_q <= 1'b0;
            done_q         <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_word)
                    OFF_CTRL: begin
                        if (wr_strb[0]) begin
                            auto_restart_q <= wr_data[CTRL_AUTO_RESTART];
                        end
                    end
                    OFF_ACTIVE_H:
                        cfg_q.height <= CFG_DIM_W'(apply_strb(AXI_DATA_W'(cfg_q.height), wr_data, wr_strb));
                    OFF_ACTIVE_W:
                        cfg_q.width <= CFG_DIM_W'(apply_strb(AXI_DATA_W'(cfg_q.width), wr_data, wr_strb));
                    OFF_BG_PATTERN:
                        cfg_q.bg_id <= 8'(apply_strb(AXI_DATA_W'(cfg_q.bg_id), wr_data, wr_strb));
                    OFF_COLOR_FORMAT:
                        cfg_q.color_fmt <= 8'(apply_strb(AXI_DATA_W'(cfg_q.color_fmt), wr_data, wr_strb));
                    default: ;
                endcase
            end

            // Writing a 1 sets start; in free-running mode ap_ready never clears it.
            if (wr_ctrl && wr_strb[0] && wr_data[CTRL_AP_START]) begin
                ap_start <= 1'b1;
            end else if (ap_ready && !auto_restart_q) begin
                ap_start <= 1'b0;
            end

            // Sticky flags: a coincident pulse beats the clear-on-read.
            if (ap_done) begin
                done_q <= 1'b1;
            end else if (rd_ctrl) begin
                done_q <= 1'b0;
            end
            if (ap_ready) begin
                ready_q <= 1'b1;
            end else if (rd_ctrl) begin
                ready_q <= 1'b0;
            end

            if (ap_start && ap_ready) begin
                shadow_q <= cfg_q;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_word)
            OFF_CTRL: begin
                rd_data[CTRL_AP_START]     = ap_start;
                rd_data[CTRL_AP_DONE]      = done_q;
                rd_data[CTRL_AP_IDLE]      = ap_idle;
                rd_data[CTRL_AP_READY]     = ready_q;
                rd_data[CTRL_AUTO_RESTART] = auto_restart_q;
            end
            OFF_ACTIVE_H:     rd_data = AXI_DATA_W'(cfg_q.height);
            OFF_ACTIVE_W:     rd_data = AXI_DATA_W'(cfg_q.width);
            OFF_BG_PATTERN:   rd_data = AXI_DATA_W'(cfg_q.bg_id);
            OFF_COLOR_FORMAT: rd_data = AXI_DATA_W'(cfg_q.color_fmt);
            default:          rd_err  = 1'b1;
        endcase
    end

endmodule

// File: doc/tpg_axil_regs.md
# tpg_axil_regs

AXI4-Lite slave register file and control handshake for the video test pattern generator core. It answers the configuration writes and status reads issued by the system AXI master (VIP in simulation, processor in hardware). It also drives the ap_start/ap_ready/ap_done control protocol towards the pattern core. Frame parameters are shadowed so that they change only at frame boundaries.

## Interface
- ADDR_W, 12: AXI4-Lite address width; bits [1:0] ignored.
- DATA_W, 32: AXI4-Lite data width; fixed at 32.
- DIM_W, 16: width of the height/width fields.
- aclk  in  1  single clock for the AXI interface and the core interface.
- areset  in  1  synchronous, active-high reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- ap_start  out  1  start request to the core.
- ap_ready  in  1  one-cycle pulse: the core has taken the start and latched the frame parameters.
- ap_done  in  1  one-cycle pulse: frame complete.
- ap_idle  in  1  level: core idle.
- frame_height, frame_width  out  DIM_W  shadowed active height and width.
- frame_bg_id, frame_color_fmt  out  8  shadowed background pattern ID and color format.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL: bit0 ap_start (RW1S); bit1 ap_done (RO, clear-on-read); bit2 ap_idle (RO, live); bit3 ap_ready (RO, clear-on-read); bit7 auto_restart (RW).
  - 0x10 ACTIVE_H [DIM_W-1:0].
  - 0x18 ACTIVE_W [DIM_W-1:0].
  - 0x20 BG_PATTERN_ID [7:0].
  - 0x40 COLOR_FORMAT [7:0].
  - All other bits read 0.
- Unmapped offsets: writes are discarded with BRESP=SLVERR (2'b10); reads return 0 with RRESP=SLVERR. Mapped accesses return OKAY.
- WSTRB is honoured per byte. Bytes beyond a field's width are ignored.
- Writing 0 to ap_start has no effect. ap_start clears on ap_ready when auto_restart=0. It stays set when auto_restart=1; writing 0x81 therefore gives free-running mode.
- Sticky flags: ap_done and ap_ready set on their input pulses. A read of CTRL clears them. If a pulse coincides with the clearing read, set wins: the read returns the old value and the flag stays 1.
- Shadowing: the frame_* outputs load from ACTIVE_H/W, BG_PATTERN_ID and COLOR_FORMAT on any cycle with ap_start && ap_ready, and on reset. A register write in that same cycle is not captured until the next frame. Reads always return the AXI-side value.
- Reset values: all AXI *ready and *valid outputs 0, rdata 0, resp 0, ap_start 0, auto_restart 0, flags 0. Registers and frame_* outputs reset to height 0, width 0, bg 0, format 0.

## Timing
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - awready=1 in IDLE and HAVE_W. wready=1 in IDLE and HAVE_AW.
  - When both address and data are held (same-cycle or staggered), the register is updated at the next edge and bvalid=1 from that cycle (1-cycle latency after the later handshake).
  - In RESP, hold bvalid until bready, then return to IDLE. No new AW/W is accepted in RESP.
- Read FSM states: IDLE, RESP.
  - arready=1 in IDLE. After the AR handshake, rvalid=1 next cycle with registered rdata/rresp. rdata, rresp and rvalid hold until rready.
  - The clear-on-read side effect fires on the AR handshake cycle.
- Read and write FSMs are independent. On a same-cycle read and write of the same register, the read returns the pre-write value.
- Reset mid-transaction: both FSMs go to IDLE and all valid outputs drop in the next cycle. Pending transactions are dropped.

## Structure
- Shared package tpg_regs_pkg:
  - register offset constants;
  - CTRL bit-index constants;
  - AXI resp constants (OKAY, SLVERR);
  - a packed struct tpg_cfg_t holding height, width, bg_id and color_fmt, used for both the register set and the shadow.
- One sub-module, axil_slave_if: the AW/W/B and AR/R FSMs. It presents a simple wr_en/wr_addr/wr_data/wr_strb plus rd_en/rd_addr/rd_data/rd_err interface to the register-file top.

## Test plan
- Reset, then write 0x10=600, 0x18=800, 0x20=9, 0x40=2 -> BRESP OKAY each time; readback returns 600, 800, 9, 2; frame_* outputs stay 0.
- Write 0x00=0x81, then pulse ap_ready -> frame_height/width = 600/800 on the next cycle; ap_start stays 1; CTRL read = 0x89; a second read = 0x81.
- Write 0x00=0x01 and pulse ap_ready -> ap_start drops the cycle after. Write 0x00=0x00 while ap_start=1 -> ap_start unchanged.
- AW presented 3 cycles before W, with bready held low 4 cycles -> a single write; bvalid held stable; awready/wready low until the B handshake completes.
- Read 0x0C and write 0x44 -> rresp=SLVERR with rdata=0; bresp=SLVERR; no register changes.
- ap_done pulse on the same cycle as the CTRL AR handshake -> that read shows bit1=0; the next read shows bit1=1, and the read after that shows 0.
